// File: rtl/mem_stage_lsu_if.sv
// Data-bus bundle between the MEM-stage LSU (master) and the data memory (slave).
interface mem_stage_lsu_if;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [3:0]  d_be;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic [31:0] d_rdata;

  modport master (output d_req, d_we, d_addr, d_be, d_wdata, input d_ack, d_rdata);
  modport slave  (input d_req, d_we, d_addr, d_be, d_wdata, output d_ack, d_rdata);
endinterface

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: req/ack bus access, lane steering, load extension, WB register.
// Optional ALIGN_CHECK_EN: misaligned word/half ops are dropped and flagged on align_err.
module mem_stage_lsu #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MEM_Valid,
  input  logic        MEM_DmWr,
  input  logic        MEM_LTypeSel,
  input  logic [1:0]  MEM_SaveType,
  input  logic [2:0]  MEM_LTypeExtOp,
  input  logic [1:0]  MEM_WbSel,
  input  logic [31:0] MEM_AluOut,
  input  logic [31:0] MEM_OutB,
  input  logic [4:0]  MEM_Rw,
  input  logic [29:0] MEM_PcAddOne,
  input  logic        MEM_RfWr,
  mem_stage_lsu_if.master bus,
  output logic        mem_stall,
  output logic        bus_err,
`ifdef ALIGN_CHECK_EN
  output logic        align_err,
`endif
  output logic        WB_RfWr,
  output logic [4:0]  WB_Rw,
  output logic [31:0] WB_Data
);
  localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2;
  localparam logic [1:0] W_WORD = 2'd0, W_HALF = 2'd1, W_BYTE = 2'd2;
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);

  logic [1:0]  state;
  logic [7:0]  cnt;
  logic [31:0] ld_data;
  logic        no_wb;

  logic        accept, issue, timeout;
  logic [1:0]  a, width;
  logic [3:0]  be_n;
  logic [31:0] wdata_n, ext_data, wb_data;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  assign a       = MEM_AluOut[1:0];
  assign accept  = (state == IDLE) & MEM_Valid & (MEM_DmWr | MEM_LTypeSel);
  assign timeout = (state == REQ) & ~bus.d_ack & (cnt == TO_LAST);
  // Held low during reset so a frozen pipeline is released immediately.
  assign mem_stall = ~rst & (accept | (state == REQ));

`ifdef ALIGN_CHECK_EN
  assign issue = accept & ~(((width == W_WORD) & (a != 2'b00)) | ((width == W_HALF) & a[0]));
`else
  assign issue = accept;
`endif

  always_comb begin
    width = W_WORD;
    if (MEM_DmWr) begin
      if (MEM_SaveType == 2'b01)      width = W_HALF;
      else if (MEM_SaveType == 2'b10) width = W_BYTE;
    end else begin
      case (MEM_LTypeExtOp)
        3'b001, 3'b010: width = W_BYTE;
        3'b011, 3'b100: width = W_HALF;
        default:        width = W_WORD;
      endcase
    end
  end

  always_comb begin
    be_n    = 4'b1111;
    wdata_n = MEM_OutB;
    case (width)
      W_HALF: begin
        be_n    = 4'b0011 << {a[1], 1'b0};
        wdata_n = {2{MEM_OutB[15:0]}};
      end
      W_BYTE: begin
        be_n    = 4'b0001 << a;
        wdata_n = {4{MEM_OutB[7:0]}};
      end
      default: ;
    endcase
  end

  // Address bits are still held on MEM_AluOut while the op sits in REQ.
  always_comb begin
    lane_h = a[1] ? bus.d_rdata[31:16] : bus.d_rdata[15:0];
    case (a)
      2'd1:    lane_b = bus.d_rdata[15:8];
      2'd2:    lane_b = bus.d_rdata[23:16];
      2'd3:    lane_b = bus.d_rdata[31:24];
      default: lane_b = bus.d_rdata[7:0];
    endcase
    ext_data = bus.d_rdata;
    case (MEM_LTypeExtOp)
      3'b001:  ext_data = {{24{lane_b[7]}}, lane_b};
      3'b010:  ext_data = {24'b0, lane_b};
      3'b011:  ext_data = {{16{lane_h[15]}}, lane_h};
      3'b100:  ext_data = {16'b0, lane_h};
      default: ;
    endcase
  end

  always_comb begin
    case (MEM_WbSel)
      2'b01:   wb_data = ld_data;
      2'b10:   wb_data = {MEM_PcAddOne, 2'b00};
      default: wb_data = MEM_AluOut;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= 8'd0;
      ld_data     <= 32'd0;
      no_wb       <= 1'b0;
      bus.d_req   <= 1'b0;
      bus.d_we    <= 1'b0;
      bus.d_addr  <= 32'd0;
      bus.d_be    <= 4'd0;
      bus.d_wdata <= 32'd0;
      bus_err     <= 1'b0;
`ifdef ALIGN_CHECK_EN
      align_err   <= 1'b0;
`endif
      WB_RfWr     <= 1'b0;
      WB_Rw       <= 5'd0;
      WB_Data     <= 32'd0;
    end else begin
      bus_err <= 1'b0;
`ifdef ALIGN_CHECK_EN
      align_err <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (accept) begin
            WB_RfWr <= 1'b0;
            no_wb   <= 1'b0;
            if (issue) begin
              bus.d_req   <= 1'b1;
              bus.d_we    <= MEM_DmWr;
              bus.d_addr  <= {MEM_AluOut[31:2], 2'b00};
              bus.d_be    <= be_n;
              bus.d_wdata <= wdata_n;
              cnt         <= 8'd0;
              state       <= REQ;
            end
`ifdef ALIGN_CHECK_EN
            else begin
              align_err <= 1'b1;
              no_wb     <= 1'b1;
              state     <= DONE;
            end
`endif
          end else begin
            WB_RfWr <= MEM_Valid & MEM_RfWr;
            WB_Rw   <= MEM_Rw;
            WB_Data <= wb_data;
          end
        end
        REQ: begin
          WB_RfWr <= 1'b0;
          if (bus.d_ack) begin
            bus.d_req <= 1'b0;
            ld_data   <= ext_data;
            state     <= DONE;
          end else if (timeout) begin
            bus.d_req <= 1'b0;
            bus_err   <= 1'b1;
            no_wb     <= 1'b1;
            state     <= DONE;
          end else if (cnt != 8'hFF) begin
            cnt <= cnt + 8'd1;
          end
        end
        DONE: begin
          WB_RfWr <= ~no_wb & ~MEM_DmWr & MEM_RfWr;
          WB_Rw   <= MEM_Rw;
          WB_Data <= wb_data;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_stage_lsu.sv
// Scoreboard bench for mem_stage_lsu: byte-addressed reference memory, random bus slave.
module tb_mem_stage_lsu;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        MEM_Valid, MEM_DmWr, MEM_LTypeSel, MEM_RfWr;
  logic [1:0]  MEM_SaveType, MEM_WbSel;
  logic [2:0]  MEM_LTypeExtOp;
  logic [31:0] MEM_AluOut, MEM_OutB;
  logic [4:0]  MEM_Rw;
  logic [29:0] MEM_PcAddOne;
  logic        mem_stall, bus_err, WB_RfWr;
  logic [4:0]  WB_Rw;
  logic [31:0] WB_Data;
`ifdef ALIGN_CHECK_EN
  logic        align_err;
`endif

  mem_stage_lsu_if bus();

  mem_stage_lsu #(.TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst(rst),
    .MEM_Valid(MEM_Valid), .MEM_DmWr(MEM_DmWr), .MEM_LTypeSel(MEM_LTypeSel),
    .MEM_SaveType(MEM_SaveType), .MEM_LTypeExtOp(MEM_LTypeExtOp), .MEM_WbSel(MEM_WbSel),
    .MEM_AluOut(MEM_AluOut), .MEM_OutB(MEM_OutB), .MEM_Rw(MEM_Rw),
    .MEM_PcAddOne(MEM_PcAddOne), .MEM_RfWr(MEM_RfWr),
    .bus(bus),
    .mem_stall(mem_stall), .bus_err(bus_err),
`ifdef ALIGN_CHECK_EN
    .align_err(align_err),
`endif
    .WB_RfWr(WB_RfWr), .WB_Rw(WB_Rw), .WB_Data(WB_Data)
  );

  typedef struct {
    logic valid, dmwr, lsel, rfwr;
    logic [1:0] save, wbsel;
    logic [2:0] ext;
    logic [31:0] alu, outb;
    logic [4:0] rw;
    logic [29:0] pc;
  } op_t;
  typedef struct { logic we; logic [31:0] addr; logic [3:0] be; logic [31:0] wdata; } bus_t;
  typedef struct { logic [4:0] rw; logic [31:0] data; } wb_t;

  bus_t bus_q[$];
  wb_t  wb_q[$];
  int   comps = 0, fails = 0;

  logic [7:0]  model_mem [logic [31:0]];
  logic [31:0] slave_mem [logic [29:0]];
  bit no_ack = 0, stray = 0;
  int force_wait = -1;
  logic        last_we;
  logic [31:0] last_addr, last_wdata;
  logic [3:0]  last_be;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    comps++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input logic [29:0] w);
    return ({w, 2'b00} * 32'h9E3779B1) ^ 32'h5A5AC3C3;
  endfunction

  function automatic logic [7:0] model_rd(input logic [31:0] addr);
    logic [31:0] w;
    if (model_mem.exists(addr)) return model_mem[addr];
    w = init_word(addr[31:2]) >> (8 * addr[1:0]);
    return w[7:0];
  endfunction

  task automatic preload(input logic [31:0] addr, input logic [31:0] w);
    slave_mem[addr[31:2]] = w;
    for (int i = 0; i < 4; i++) model_mem[{addr[31:2], 2'b00} + i] = w[8*i +: 8];
  endtask

  function automatic logic [31:0] wb_val(input op_t o, input logic [31:0] ld);
    case (o.wbsel)
      2'b01:   return ld;
      2'b10:   return {o.pc, 2'b00};
      default: return o.alu;
    endcase
  endfunction

  // Reference: memory is a flat byte array; an op touches nb bytes starting at base.
  task automatic model_op(input op_t o);
    int nb; logic [31:0] base, val; logic [1:0] a; bus_t b; wb_t w;
    if (!o.valid) return;
    if (!(o.dmwr || o.lsel)) begin
      if (o.rfwr) begin w.rw = o.rw; w.data = wb_val(o, 32'd0); wb_q.push_back(w); end
      return;
    end
    a = o.alu[1:0];
    if (o.dmwr) nb = (o.save == 2'b01) ? 2 : (o.save == 2'b10) ? 1 : 4;
    else nb = (o.ext == 3'b001 || o.ext == 3'b010) ? 1 : (o.ext == 3'b011 || o.ext == 3'b100) ? 2 : 4;
`ifdef ALIGN_CHECK_EN
    if ((nb == 4 && a != 2'b00) || (nb == 2 && a[0])) return;
`endif
    base = (nb == 4) ? {o.alu[31:2], 2'b00} : (nb == 2) ? {o.alu[31:2], a[1], 1'b0} : o.alu;
    b.addr = {o.alu[31:2], 2'b00};
    b.be = 4'(((1 << nb) - 1) << base[1:0]);
    b.we = o.dmwr;
    if (o.dmwr) begin
      b.wdata = (nb == 4) ? o.outb : (nb == 2) ? {2{o.outb[15:0]}} : {4{o.outb[7:0]}};
      for (int i = 0; i < nb; i++) model_mem[base + i] = o.outb[8*i +: 8];
      bus_q.push_back(b);
    end else begin
      b.wdata = 32'd0;
      val = 32'd0;
      for (int i = 0; i < nb; i++) val |= 32'(model_rd(base + i)) << (8 * i);
      if (o.ext == 3'b001 && val[7])  val |= 32'hFFFFFF00;
      if (o.ext == 3'b011 && val[15]) val |= 32'hFFFF0000;
      bus_q.push_back(b);
      if (o.rfwr) begin w.rw = o.rw; w.data = wb_val(o, val); wb_q.push_back(w); end
    end
  endtask

  task automatic drive(input op_t o);
    MEM_Valid = o.valid; MEM_DmWr = o.dmwr; MEM_LTypeSel = o.lsel; MEM_RfWr = o.rfwr;
    MEM_SaveType = o.save; MEM_WbSel = o.wbsel; MEM_LTypeExtOp = o.ext;
    MEM_AluOut = o.alu; MEM_OutB = o.outb; MEM_Rw = o.rw; MEM_PcAddOne = o.pc;
  endtask

  // Present one op in MEM and hold it while the stage stalls; count what the op produced.
  task automatic issue(input op_t o, input bit use_model, output int ns, output int nr,
                       output int ne, output int na);
    bit st, done;
    ns = 0; nr = 0; ne = 0; na = 0; done = 0;
    drive(o);
    if (use_model) model_op(o);
    for (int k = 0; k < 100 && !done; k++) begin
      @(negedge clk);
      st = mem_stall;
      ns += int'(st); nr += int'(bus.d_req); ne += int'(bus_err);
`ifdef ALIGN_CHECK_EN
      na += int'(align_err);
`endif
      @(posedge clk); #1;
      if (!st) done = 1;
    end
    if (!done) chk("stall_bound", 32'd1, 32'd0);
  endtask

  function automatic op_t mk(input logic lsel, input logic dmwr, input logic [2:0] ext,
                             input logic [1:0] save, input logic [31:0] alu, input logic [31:0] outb);
    op_t o;
    o.valid = 1; o.lsel = lsel; o.dmwr = dmwr; o.ext = ext; o.save = save;
    o.alu = alu; o.outb = outb; o.rw = 5'd7; o.pc = 30'h123; o.rfwr = 1;
    o.wbsel = lsel ? 2'b01 : 2'b00;
    return o;
  endfunction

  function automatic op_t rand_op();
    op_t o; int k;
    k = $urandom_range(0, 3);
    o.valid = (k != 1); o.dmwr = 0; o.lsel = 0;
    o.save = 2'($urandom_range(0, 3)); o.ext = 3'($urandom_range(0, 7));
    o.alu = 32'h400 + 32'($urandom_range(0, 63)); o.outb = $urandom;
    o.rw = 5'($urandom); o.pc = 30'($urandom); o.rfwr = ($urandom_range(0, 3) != 0);
    o.wbsel = 2'($urandom_range(0, 3));
    case (k)
      0: if (o.wbsel == 2'b01) o.wbsel = 2'b10;
      1: begin o.dmwr = 1'($urandom_range(0, 1)); o.lsel = ~o.dmwr; end
      2: begin o.lsel = 1; o.wbsel = ($urandom_range(0, 3) == 0) ? 2'b00 : 2'b01; end
      default: o.dmwr = 1;
    endcase
    return o;
  endfunction

  // Bus slave: random wait states, word memory written under byte enables.
  initial begin
    int wl;
    logic [31:0] w;
    wl = -1;
    bus.d_ack = 0; bus.d_rdata = 32'd0;
    forever begin
      @(posedge clk); #1;
      bus.d_ack = 0;
      if (stray) bus.d_ack = 1;
      else if (bus.d_req && !no_ack) begin
        if (wl < 0) wl = (force_wait >= 0) ? force_wait : $urandom_range(0, 3);
        if (wl == 0) begin
          w = slave_mem.exists(bus.d_addr[31:2]) ? slave_mem[bus.d_addr[31:2]] : init_word(bus.d_addr[31:2]);
          bus.d_ack = 1;
          bus.d_rdata = bus.d_we ? $urandom : w;
          if (bus.d_we) begin
            for (int i = 0; i < 4; i++) if (bus.d_be[i]) w[8*i +: 8] = bus.d_wdata[8*i +: 8];
            slave_mem[bus.d_addr[31:2]] = w;
          end
          wl = -1;
        end else wl--;
      end else if (!bus.d_req) wl = -1;
    end
  end

  // Monitor: completed bus transfers and WB writes against the expectation queues.
  always @(negedge clk) begin
    bus_t b; wb_t w;
    if (bus.d_req && bus.d_ack) begin
      last_we = bus.d_we; last_addr = bus.d_addr; last_be = bus.d_be; last_wdata = bus.d_wdata;
      if (bus_q.size() == 0) chk("bus_unexpected", 32'd1, 32'd0);
      else begin
        b = bus_q.pop_front();
        chk("d_we", 32'(bus.d_we), 32'(b.we));
        chk("d_addr", bus.d_addr, b.addr);
        chk("d_be", 32'(bus.d_be), 32'(b.be));
        if (b.we) chk("d_wdata", bus.d_wdata, b.wdata);
      end
    end
    if (WB_RfWr) begin
      if (wb_q.size() == 0) chk("wb_unexpected", 32'd1, 32'd0);
      else begin
        w = wb_q.pop_front();
        chk("WB_Rw", 32'(WB_Rw), 32'(w.rw));
        chk("WB_Data", WB_Data, w.data);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    op_t o, idle;
    int ns, nr, ne, na;
    idle = mk(0, 0, 3'd0, 2'd0, 32'd0, 32'd0);
    idle.valid = 0;
    drive(idle);
    rst = 1;
    @(negedge clk);
    chk("rst_d_req", 32'(bus.d_req), 32'd0);
    chk("rst_d_we", 32'(bus.d_we), 32'd0);
    chk("rst_d_addr", bus.d_addr, 32'd0);
    chk("rst_d_be", 32'(bus.d_be), 32'd0);
    chk("rst_d_wdata", bus.d_wdata, 32'd0);
    chk("rst_stall", 32'(mem_stall), 32'd0);
    chk("rst_bus_err", 32'(bus_err), 32'd0);
    chk("rst_WB_RfWr", 32'(WB_RfWr), 32'd0);
    chk("rst_WB_Rw", 32'(WB_Rw), 32'd0);
    chk("rst_WB_Data", WB_Data, 32'd0);
    rst = 0;
    @(posedge clk); #1;

    // lw, ack in the first REQ cycle
    preload(32'h100, 32'hDEADBEEF);
    force_wait = 0;
    issue(mk(1, 0, 3'b000, 2'd0, 32'h100, 32'd0), 1, ns, nr, ne, na);
    chk("lw_stall_cycles", 32'(ns), 32'd2);
    chk("lw_req_cycles", 32'(nr), 32'd1);
    chk("lw_be", 32'(last_be), 32'hF);
    chk("lw_wb_data", WB_Data, 32'hDEADBEEF);
    chk("lw_wb_rfwr", 32'(WB_RfWr), 32'd1);

    // lw at 0x101: dropped with align check, low bits ignored otherwise
    issue(mk(1, 0, 3'b000, 2'd0, 32'h101, 32'd0), 1, ns, nr, ne, na);
`ifdef ALIGN_CHECK_EN
    chk("mis_req_cycles", 32'(nr), 32'd0);
    chk("mis_align_err", 32'(na), 32'd1);
    chk("mis_stall_cycles", 32'(ns), 32'd1);
    chk("mis_wb_rfwr", 32'(WB_RfWr), 32'd0);
`else
    chk("mis_addr", last_addr, 32'h100);
    chk("mis_wb_data", WB_Data, 32'hDEADBEEF);
`endif

    // lb / lbu at 0x103
    preload(32'h100, 32'h80123456);
    issue(mk(1, 0, 3'b001, 2'd0, 32'h103, 32'd0), 1, ns, nr, ne, na);
    chk("lb_be", 32'(last_be), 32'h8);
    chk("lb_wb_data", WB_Data, 32'hFFFFFF80);
    issue(mk(1, 0, 3'b010, 2'd0, 32'h103, 32'd0), 1, ns, nr, ne, na);
    chk("lbu_wb_data", WB_Data, 32'h00000080);

    // sh at 0x202
    issue(mk(0, 1, 3'b000, 2'b01, 32'h202, 32'h1234ABCD), 1, ns, nr, ne, na);
    chk("sh_we", 32'(last_we), 32'd1);
    chk("sh_be", 32'(last_be), 32'hC);
    chk("sh_wdata", last_wdata, 32'hABCDABCD);
    chk("sh_wb_rfwr", 32'(WB_RfWr), 32'd0);
    force_wait = -1;

    // Timeout, then a stray ack while idle
    no_ack = 1;
    issue(mk(1, 0, 3'b000, 2'd0, 32'h300, 32'd0), 0, ns, nr, ne, na);
    chk("to_req_cycles", 32'(nr), 32'd16);
    chk("to_bus_err", 32'(ne), 32'd1);
    chk("to_stall_cycles", 32'(ns), 32'd17);
    chk("to_wb_rfwr", 32'(WB_RfWr), 32'd0);
    no_ack = 0; stray = 1;
    issue(idle, 1, ns, nr, ne, na);
    issue(idle, 1, ns, nr, ne, na);
    chk("stray_req", 32'(nr), 32'd0);
    chk("stray_stall", 32'(ns), 32'd0);
    stray = 0;

    // Reset after 3 wait cycles in REQ
    no_ack = 1;
    drive(mk(1, 0, 3'b000, 2'd0, 32'h304, 32'd0));
    @(posedge clk);
    repeat (3) @(posedge clk);
    #2;
    chk("mid_req_before_rst", 32'(bus.d_req), 32'd1);
    rst = 1;
    #1;
    chk("rst_mid_d_req", 32'(bus.d_req), 32'd0);
    chk("rst_mid_stall", 32'(mem_stall), 32'd0);
    drive(idle);
    @(negedge clk);
    rst = 0; no_ack = 0;
    @(posedge clk); #1;

    for (int n = 0; n < 400; n++) begin
      o = rand_op();
      issue(o, 1, ns, nr, ne, na);
    end
    drive(idle);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("bus_q_drained", 32'(bus_q.size()), 32'd0);
    chk("wb_q_drained", 32'(wb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", comps, fails);
    $finish;
  end
endmodule
